// File: rtl/lrpt_pkg.sv
// Shared types and helpers for the LRPT soft-symbol path.
package lrpt_pkg;

  typedef enum logic [1:0] {
    ST_FLUSH,
    ST_SLIP,
    ST_EVAL,
    ST_LOCKED
  } vit_ctrl_state_t;

  // bit0 = invert polarity, bit1 = symbol-pair slip parity
  typedef logic [1:0] hyp_t;

  // Two's-complement negation that maps -128 to +127 instead of wrapping.
  function automatic logic [7:0] sat_neg8(input logic [7:0] x);
    return (x == 8'h80) ? 8'h7F : (~x + 8'd1);
  endfunction

endpackage

// File: rtl/viterbi_sync_ctrl_if.sv
// Soft-symbol stream in, decoder-side stream and control out.
interface viterbi_sync_ctrl_if;
  logic [7:0] soft_in;
  logic       soft_valid;
  logic       soft_ready;
  logic [7:0] vit_soft;
  logic       vit_valid;
  logic       vit_ready;
  logic       vit_norm;
  logic       vit_rst;

  modport master (
    input  soft_in, soft_valid, vit_ready, vit_norm,
    output soft_ready, vit_soft, vit_valid, vit_rst
  );

  modport slave (
    output soft_in, soft_valid, vit_ready, vit_norm,
    input  soft_ready, vit_soft, vit_valid, vit_rst
  );
endinterface

// File: rtl/viterbi_sync_ctrl_window.sv
// Per-window symbol and normalization counting with a latched result.
module vit_window_monitor #(
  parameter int unsigned WINDOW = 1024
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_clr,
  input  logic        i_accept,
  input  logic        i_norm,
  output logic        o_window_done,
  output logic [15:0] o_window_cnt,
  output logic [15:0] o_norm_cnt
);
  localparam int unsigned SW = $clog2(WINDOW);

  logic [SW-1:0] r_sym_cnt;
  logic [15:0]   r_norm_acc;
  logic [15:0]   r_norm_cnt;

  // Count including a pulse coincident with this cycle, so the window-ending
  // accept sees its own normalization.
  always_comb begin
    o_window_cnt = r_norm_acc;
    if (i_norm && (r_norm_acc != '1))
      o_window_cnt = r_norm_acc + 16'd1;
  end

  // WINDOW is a power of two, so the last symbol is the all-ones count.
  assign o_window_done = i_accept && (&r_sym_cnt);
  assign o_norm_cnt    = r_norm_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sym_cnt  <= '0;
      r_norm_acc <= '0;
      r_norm_cnt <= '0;
    end else if (i_clr) begin
      r_sym_cnt  <= '0;
      r_norm_acc <= '0;
    end else if (o_window_done) begin
      r_sym_cnt  <= '0;
      r_norm_acc <= '0;
      r_norm_cnt <= o_window_cnt;
    end else begin
      if (i_accept)
        r_sym_cnt <= r_sym_cnt + 1'b1;
      r_norm_acc <= o_window_cnt;
    end
  end

endmodule

// File: rtl/viterbi_sync_ctrl.sv
// Steps polarity/slip hypotheses ahead of the Viterbi decoder and grades each
// by normalization rate per window; holds lock while monitoring.
module viterbi_sync_ctrl
  import lrpt_pkg::*;
#(
  parameter int unsigned WINDOW        = 1024,
  parameter int unsigned LOCK_THRESH   = 8,
  parameter int unsigned UNLOCK_THRESH = 24,
  parameter int unsigned FLUSH_CYCLES  = 4
) (
  input  logic                        clk,
  input  logic                        sys_rst,
  viterbi_sync_ctrl_if.master         bus,
  output logic                        locked,
  output hyp_t                        hyp,
  output logic [15:0]                 norm_cnt
);
  localparam int unsigned   FW         = $clog2(FLUSH_CYCLES + 1);
  localparam logic [FW-1:0] FLUSH_LAST = FW'(FLUSH_CYCLES - 1);
  localparam logic [15:0]   LOCK_T     = 16'(LOCK_THRESH);
  localparam logic [15:0]   UNLOCK_T   = 16'(UNLOCK_THRESH);

  vit_ctrl_state_t r_state, w_state_nxt;
  logic [FW-1:0]   r_flush_cnt, w_flush_nxt;
  hyp_t            r_hyp, w_hyp_nxt;
  logic            r_locked, w_locked_nxt;
  logic            r_slip_pending, w_slip_nxt;
  logic            r_vit_rst;

  logic            w_in_data;
  logic            w_accept;
  logic            w_norm;
  logic            w_window_done;
  logic [15:0]     w_window_cnt;
  logic            w_advance;

  assign w_in_data = (r_state == ST_EVAL) || (r_state == ST_LOCKED);
  assign w_accept  = w_in_data && bus.soft_valid && bus.vit_ready;
  assign w_norm    = w_in_data && bus.vit_norm;

  vit_window_monitor #(
    .WINDOW (WINDOW)
  ) u_window (
    .i_clk         (clk),
    .i_rst_n       (sys_rst),
    .i_clr         (r_state == ST_FLUSH),
    .i_accept      (w_accept),
    .i_norm        (w_norm),
    .o_window_done (w_window_done),
    .o_window_cnt  (w_window_cnt),
    .o_norm_cnt    (norm_cnt)
  );

  always_comb begin
    bus.soft_ready = 1'b0;
    bus.vit_valid  = 1'b0;
    bus.vit_soft   = '0;
    case (r_state)
      ST_SLIP: bus.soft_ready = 1'b1;
      ST_EVAL, ST_LOCKED: begin
        bus.soft_ready = bus.vit_ready;
        bus.vit_valid  = bus.soft_valid & bus.vit_ready;
        bus.vit_soft   = r_hyp[0] ? sat_neg8(bus.soft_in) : bus.soft_in;
      end
      default: ;
    endcase
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_flush_nxt  = '0;
    w_hyp_nxt    = r_hyp;
    w_locked_nxt = r_locked;
    w_slip_nxt   = r_slip_pending;
    w_advance    = 1'b0;
    case (r_state)
      ST_FLUSH: begin
        if (r_flush_cnt == FLUSH_LAST)
          w_state_nxt = r_slip_pending ? ST_SLIP : ST_EVAL;
        else
          w_flush_nxt = r_flush_cnt + 1'b1;
      end
      ST_SLIP: begin
        if (bus.soft_valid) begin
          w_state_nxt = ST_EVAL;
          w_slip_nxt  = 1'b0;
        end
      end
      ST_EVAL: begin
        if (w_window_done) begin
          if (w_window_cnt <= LOCK_T) begin
            w_state_nxt  = ST_LOCKED;
            w_locked_nxt = 1'b1;
          end else begin
            w_advance = 1'b1;
          end
        end
      end
      ST_LOCKED: begin
        if (w_window_done && (w_window_cnt > UNLOCK_T))
          w_advance = 1'b1;
      end
      default: w_state_nxt = ST_FLUSH;
    endcase
    // hyp[1] toggles exactly when the old hyp[0] is set (1->2, 3->0).
    if (w_advance) begin
      w_hyp_nxt    = r_hyp + 2'd1;
      w_slip_nxt   = r_hyp[0];
      w_locked_nxt = 1'b0;
      w_state_nxt  = ST_FLUSH;
    end
  end

  always_ff @(posedge clk or negedge sys_rst) begin
    if (!sys_rst) begin
      r_state        <= ST_FLUSH;
      r_flush_cnt    <= '0;
      r_hyp          <= '0;
      r_locked       <= 1'b0;
      r_slip_pending <= 1'b0;
      r_vit_rst      <= 1'b1;
    end else begin
      r_state        <= w_state_nxt;
      r_flush_cnt    <= w_flush_nxt;
      r_hyp          <= w_hyp_nxt;
      r_locked       <= w_locked_nxt;
      r_slip_pending <= w_slip_nxt;
      r_vit_rst      <= (w_state_nxt == ST_FLUSH);
    end
  end

  assign bus.vit_rst = r_vit_rst;
  assign locked      = r_locked;
  assign hyp         = r_hyp;

endmodule
